// File: rtl/riscv_io_router_if.sv
// Bundles for the router: core-side IO port and the shared channel request/response bus.
// In each bundle the master drives requests and the slave drives responses.
interface riscv_io_router_if #(
  parameter int DATA_WIDTH = 128,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int ADDR_WIDTH = 22
);
  logic                  io_en;
  logic                  io_wen;
  logic [ADDR_WIDTH-1:0] io_addr;
  logic [STRB_WIDTH-1:0] io_strb;
  logic [DATA_WIDTH-1:0] io_wr_data;
  logic                  io_ready;
  logic [DATA_WIDTH-1:0] io_rd_data;
  logic                  io_rd_valid;
  logic                  io_wr_done;
  logic                  io_err;
  logic [15:0]           err_count;

  modport master (
    output io_en, io_wen, io_addr, io_strb, io_wr_data,
    input  io_ready, io_rd_data, io_rd_valid, io_wr_done, io_err, err_count
  );
  modport slave (
    input  io_en, io_wen, io_addr, io_strb, io_wr_data,
    output io_ready, io_rd_data, io_rd_valid, io_wr_done, io_err, err_count
  );
endinterface

interface riscv_io_ch_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 128,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int ADDR_WIDTH = 22
);
  logic [NUM_CH-1:0]            ch_req_valid;
  logic                         ch_req_wen;
  logic [ADDR_WIDTH-1:0]        ch_req_addr;
  logic [STRB_WIDTH-1:0]        ch_req_strb;
  logic [DATA_WIDTH-1:0]        ch_req_wr_data;
  logic [NUM_CH-1:0]            ch_req_ready;
  logic [NUM_CH-1:0]            ch_resp_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_resp_data;

  modport master (
    output ch_req_valid, ch_req_wen, ch_req_addr, ch_req_strb, ch_req_wr_data,
    input  ch_req_ready, ch_resp_valid, ch_resp_data
  );
  modport slave (
    input  ch_req_valid, ch_req_wen, ch_req_addr, ch_req_strb, ch_req_wr_data,
    output ch_req_ready, ch_resp_valid, ch_resp_data
  );
endinterface

// File: rtl/riscv_io_router.sv
// Single-outstanding IO router from the core's IO port to NUM_CH valid/ready channels,
// with per-transaction timeout and a saturating error counter.
//
// state  | meaning
// IDLE   | io_ready high, waiting for io_en
// REQ    | ch_req_valid[sel] asserted, waiting for ch_req_ready[sel]
// WAIT   | read accepted by channel, waiting for ch_resp_valid[sel]
// ERR    | bad channel or timeout; one-cycle errored completion
module riscv_io_router #(
  parameter int DATA_WIDTH     = 128,
  parameter int STRB_WIDTH     = DATA_WIDTH/8,
  parameter int ADDR_WIDTH     = 22,
  parameter int NUM_CH         = 4,
  parameter int CH_SEL_BITS    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int CH_ADDR_LSB    = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = $clog2(TIMEOUT_CYCLES+1)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  riscv_io_router_if.slave io,
  riscv_io_ch_if.master    ch
);
  localparam int SEL_SPAN = 1 << CH_SEL_BITS;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ERR} state_t;
  state_t r_state, w_state_next;

  logic                   r_wen;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [STRB_WIDTH-1:0]  r_strb;
  logic [DATA_WIDTH-1:0]  r_wr_data;
  logic [CH_SEL_BITS-1:0] r_sel;
  logic [TO_WIDTH-1:0]    r_to_cnt;
  logic [NUM_CH-1:0]      r_req_valid;
  logic [DATA_WIDTH-1:0]  r_rd_data;
  logic                   r_rd_valid;
  logic                   r_wr_done;
  logic                   r_err;
  logic [15:0]            r_err_count;

  logic                   w_accept;
  logic [CH_SEL_BITS-1:0] w_addr_sel;
  logic [CH_SEL_BITS-1:0] w_sel_next;
  logic [SEL_SPAN-1:0]    w_ch_exists;
  logic [SEL_SPAN-1:0]    w_rdy_pad;
  logic [SEL_SPAN-1:0]    w_resp_pad;
  logic                   w_rdy_sel;
  logic                   w_resp_sel;
  logic                   w_to_hit;
  logic [DATA_WIDTH-1:0]  w_resp_data;
  logic [NUM_CH-1:0]      w_req_valid_d;
  logic [DATA_WIDTH-1:0]  w_rd_data_d;
  logic                   w_rd_valid_d;
  logic                   w_wr_done_d;
  logic                   w_err_d;

  // Select codes beyond NUM_CH (non-power-of-2 channel counts) map to ERR.
  for (genvar g = 0; g < SEL_SPAN; g++) begin : g_exists
    assign w_ch_exists[g] = (g < NUM_CH);
  end

  assign w_addr_sel = io.io_addr[CH_ADDR_LSB +: CH_SEL_BITS];
  assign w_accept   = io.io_en && (r_state == S_IDLE);
  assign w_rdy_sel  = w_rdy_pad[r_sel];
  assign w_resp_sel = w_resp_pad[r_sel];
  assign w_to_hit   = (r_to_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_rdy_pad                = '0;
    w_resp_pad               = '0;
    w_rdy_pad[NUM_CH-1:0]    = ch.ch_req_ready;
    w_resp_pad[NUM_CH-1:0]   = ch.ch_resp_valid;
    w_resp_data              = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_sel == CH_SEL_BITS'(i)) w_resp_data = ch.ch_resp_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  // Completion is checked before the timeout so a same-cycle completion wins.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (io.io_en) w_state_next = w_ch_exists[w_addr_sel] ? S_REQ : S_ERR;
      S_REQ: begin
        if (w_rdy_sel) begin
          if (r_wen || w_resp_sel) w_state_next = S_IDLE;
          else if (w_to_hit)       w_state_next = S_ERR;
          else                     w_state_next = S_WAIT;
        end else if (w_to_hit) begin
          w_state_next = S_ERR;
        end
      end
      S_WAIT: begin
        if (w_resp_sel)    w_state_next = S_IDLE;
        else if (w_to_hit) w_state_next = S_ERR;
      end
      S_ERR:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sel_next    = (r_state == S_IDLE) ? w_addr_sel : r_sel;
    w_req_valid_d = '0;
    if (w_state_next == S_REQ) begin
      for (int i = 0; i < NUM_CH; i++) w_req_valid_d[i] = (w_sel_next == CH_SEL_BITS'(i));
    end
    w_rd_valid_d = 1'b0;
    w_wr_done_d  = 1'b0;
    w_err_d      = 1'b0;
    w_rd_data_d  = r_rd_data;
    case (r_state)
      S_REQ: begin
        if (w_rdy_sel && r_wen) begin
          w_wr_done_d = 1'b1;
        end else if (w_rdy_sel && w_resp_sel) begin
          w_rd_valid_d = 1'b1;
          w_rd_data_d  = w_resp_data;
        end
      end
      S_WAIT: begin
        if (w_resp_sel) begin
          w_rd_valid_d = 1'b1;
          w_rd_data_d  = w_resp_data;
        end
      end
      S_ERR: begin
        w_err_d = 1'b1;
        if (r_wen) begin
          w_wr_done_d = 1'b1;
        end else begin
          w_rd_valid_d = 1'b1;
          w_rd_data_d  = '1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_strb      <= '0;
      r_wr_data   <= '0;
      r_sel       <= '0;
      r_to_cnt    <= '0;
      r_req_valid <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_wr_done   <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_accept) begin
        r_wen     <= io.io_wen;
        r_addr    <= io.io_addr;
        r_strb    <= io.io_strb;
        r_wr_data <= io.io_wr_data;
        r_sel     <= w_addr_sel;
        r_to_cnt  <= '0;
      end else if (r_state == S_REQ || r_state == S_WAIT) begin
        r_to_cnt <= r_to_cnt + TO_WIDTH'(1);
      end
      r_req_valid <= w_req_valid_d;
      r_rd_data   <= w_rd_data_d;
      r_rd_valid  <= w_rd_valid_d;
      r_wr_done   <= w_wr_done_d;
      r_err       <= w_err_d;
      if (r_state == S_ERR && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
    end
  end

  assign io.io_ready       = (r_state == S_IDLE);
  assign io.io_rd_data     = r_rd_data;
  assign io.io_rd_valid    = r_rd_valid;
  assign io.io_wr_done     = r_wr_done;
  assign io.io_err         = r_err;
  assign io.err_count      = r_err_count;
  assign ch.ch_req_valid   = r_req_valid;
  assign ch.ch_req_wen     = r_wen;
  assign ch.ch_req_addr    = r_addr;
  assign ch.ch_req_strb    = r_strb;
  assign ch.ch_req_wr_data = r_wr_data;
endmodule
